// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM fill controller.
// AXI read constants and the fill FSM state encoding.
package dram_pkg;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 16;
  localparam int BURST_LEN  = 128;

  localparam logic [2:0] SIZE_2B    = 3'b001;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_RD,
    ST_FIN
  } fill_state_t;

endpackage

// File: rtl/dram_fill_ctrl.sv
// Fills a 128-word local SRAM from one AXI INCR read burst.
// Registered outputs; err is sticky per fill and valid with done.
module dram_fill_ctrl
  import dram_pkg::*;
#(
  parameter int ID_WIDTH   = dram_pkg::ID_WIDTH,
  parameter int ADDR_WIDTH = dram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = dram_pkg::DATA_WIDTH,
  parameter int BURST_LEN  = dram_pkg::BURST_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [6:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  sram_we,
  output logic [6:0]            sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [6:0] LAST_BEAT = 7'(BURST_LEN - 1);

  fill_state_t r_state;
  fill_state_t w_next;

  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_sram_we;
  logic [6:0]            r_sram_addr;
  logic [DATA_WIDTH-1:0] r_sram_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_req_ready;
  logic [6:0]            r_cnt;
  logic                  r_full;

  logic w_req;
  logic w_ar_hs;
  logic w_beat;
  logic w_at_last;
  logic w_beat_err;

  assign w_req     = (r_state == ST_IDLE) && req_valid;
  assign w_ar_hs   = (r_state == ST_AR) && r_arvalid && arready;
  assign w_beat    = (r_state == ST_RD) && r_rready && rvalid;
  assign w_at_last = (r_cnt == LAST_BEAT);
  // r_full marks that all 128 words were written; later beats are overrun.
  assign w_beat_err = (rresp != RESP_OKAY) || r_full ||
                      (rlast != w_at_last);

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (req_valid) w_next = ST_AR;
      ST_AR:   if (w_ar_hs) w_next = ST_RD;
      ST_RD:   if (w_beat && rlast) w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Registered outputs, beat counter and SRAM write stage.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_araddr     <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_req_ready  <= 1'b1;
      r_cnt        <= '0;
      r_full       <= 1'b0;
    end else begin
      r_busy      <= (w_next != ST_IDLE);
      r_req_ready <= (w_next == ST_IDLE);
      r_done      <= (r_state == ST_FIN);
      r_sram_we   <= w_beat && !r_full;
      if (w_req) begin
        r_araddr  <= req_addr;
        r_arvalid <= 1'b1;
        r_err     <= 1'b0;
      end
      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
        r_cnt     <= '0;
        r_full    <= 1'b0;
      end
      if (w_beat) begin
        r_sram_addr  <= r_cnt;
        r_sram_wdata <= rdata;
        r_cnt        <= r_cnt + 7'd1;
        if (w_at_last) r_full <= 1'b1;
        if (w_beat_err) r_err <= 1'b1;
        if (rlast) r_rready <= 1'b0;
      end
    end
  end

  assign arid       = '0;
  assign arlen      = LAST_BEAT;
  assign arsize     = SIZE_2B;
  assign arburst    = BURST_INCR;
  assign araddr     = r_araddr;
  assign arvalid    = r_arvalid;
  assign rready     = r_rready;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign req_ready  = r_req_ready;

endmodule

// File: tb/tb_dram_fill_ctrl.sv
// Scoreboard bench for dram_fill_ctrl.
// Expected SRAM writes and done/err are queued as beats are driven.
module tb_dram_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [6:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [15:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        sram_we;
  logic [6:0]  sram_addr;
  logic [15:0] sram_wdata;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [6:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t q_wr[$];
  bit  q_err[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr = 0;
  int n_done = 0;
  int cyc = 0;
  int last_wr_at = 0;
  int last_done_at = 0;
  int dofs = 0;

  dram_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop expected writes and done status.
  always @(negedge clk) begin
    if (sram_we) begin
      n_wr++;
      last_wr_at = cyc + 1;
      if (q_wr.size() == 0) begin
        chk("spurious_wr", 1, 0);
      end else begin
        wr_t e;
        e = q_wr.pop_front();
        chk("wr_addr", 32'(sram_addr), 32'(e.a));
        chk("wr_data", 32'(sram_wdata), 32'(e.d));
      end
    end
    if (done) begin
      n_done++;
      last_done_at = cyc + 1;
      if (q_err.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        bit ee;
        ee = q_err.pop_front();
        chk("done_err", 32'(err), 32'(ee));
      end
    end
  end

  task automatic do_req(input logic [31:0] a,
                        input int ar_dly,
                        input bit hold);
    int k;
    req_addr = a;
    req_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    k = 0;
    while (!arvalid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    if (!arvalid) chk("ar_timeout", 0, 1);
    chk("araddr", araddr, a);
    repeat (ar_dly) begin
      @(posedge clk); #1;
    end
    chk("ar_hold", 32'(arvalid), 1);
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chk("ar_drop", 32'(arvalid), 0);
  endtask

  task automatic beats(input int s, input int e,
                       input int last_i, input int bad_i,
                       input bit rnd);
    int i;
    int g;
    bit v;
    bit acc;
    i = s;
    g = 0;
    while (i < e && g < 2000) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rvalid = v;
      rdata = v ? 16'(i + dofs) : 16'hdead;
      rlast = v && (i == last_i);
      rresp = (v && i == bad_i) ? 2'b10 : 2'b00;
      acc = v && rready;
      if (acc && i < 128)
        q_wr.push_back('{a: 7'(i), d: 16'(i + dofs)});
      @(posedge clk); #1;
      g++;
      if (acc) i++;
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    rresp = 2'b00;
    if (i < e) chk("beat_timeout", 32'(i), 32'(e));
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (n_done == d0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_done == d0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int w0;
    int d0;
    int t0;
    int k;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_araddr", araddr, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_rready", 32'(rready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_we", 32'(sram_we), 0);
    chk("rst_saddr", 32'(sram_addr), 0);
    chk("rst_req_ready", 32'(req_ready), 1);

    // Basic fill: data = index, arready after 3 cycles.
    dofs = 0;
    w0 = n_wr;
    d0 = n_done;
    q_err.push_back(1'b0);
    req_addr = 32'h0000_1000;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ar_valid", 32'(arvalid), 1);
    chk("arid", 32'(arid), 0);
    chk("arlen", 32'(arlen), 127);
    chk("arsize", 32'(arsize), 1);
    chk("arburst", 32'(arburst), 1);
    chk("busy_on", 32'(busy), 1);
    chk("req_ready_off", 32'(req_ready), 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("ar_stable", araddr, 32'h0000_1000);
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chk("rready_on", 32'(rready), 1);
    beats(0, 128, 127, -1, 1'b0);
    wait_done(d0);
    chk("t1_writes", 32'(n_wr - w0), 128);
    chk("t1_dones", 32'(n_done - d0), 1);

    // Latency with arready and rvalid held high.
    dofs = 16'h0100;
    w0 = n_wr;
    d0 = n_done;
    q_err.push_back(1'b0);
    @(posedge clk); #1;
    arready = 1'b1;
    req_addr = 32'h0000_2000;
    req_valid = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    req_valid = 1'b0;
    beats(0, 128, 127, -1, 1'b0);
    arready = 1'b0;
    wait_done(d0);
    chk("wr_lat", 32'(last_wr_at - t0), 130);
    chk("done_lat", 32'(last_done_at - t0), 131);
    chk("t2_writes", 32'(n_wr - w0), 128);

    // Random rvalid gaps.
    dofs = 16'h0a00;
    w0 = n_wr;
    d0 = n_done;
    q_err.push_back(1'b0);
    do_req(32'h0000_3000, 1, 1'b0);
    beats(0, 128, 127, -1, 1'b1);
    wait_done(d0);
    chk("t3_writes", 32'(n_wr - w0), 128);

    // Error response on beat 40.
    dofs = 16'h2000;
    w0 = n_wr;
    d0 = n_done;
    q_err.push_back(1'b1);
    do_req(32'h0000_4000, 0, 1'b0);
    beats(0, 128, 127, 40, 1'b0);
    wait_done(d0);
    chk("t4_writes", 32'(n_wr - w0), 128);

    // Early rlast on beat 63, then a clean fill.
    dofs = 16'h3000;
    w0 = n_wr;
    d0 = n_done;
    q_err.push_back(1'b1);
    do_req(32'h0000_1000, 0, 1'b0);
    beats(0, 64, 63, -1, 1'b0);
    wait_done(d0);
    chk("t5_writes", 32'(n_wr - w0), 64);
    w0 = n_wr;
    d0 = n_done;
    q_err.push_back(1'b0);
    do_req(32'h0000_1100, 2, 1'b0);
    beats(0, 128, 127, -1, 1'b0);
    wait_done(d0);
    chk("t5b_writes", 32'(n_wr - w0), 128);

    // Overrun: rlast missing at 127, arrives on beat 129.
    dofs = 16'h4000;
    w0 = n_wr;
    d0 = n_done;
    q_err.push_back(1'b1);
    do_req(32'h0000_5000, 0, 1'b0);
    beats(0, 130, 129, -1, 1'b0);
    wait_done(d0);
    chk("ovr_writes", 32'(n_wr - w0), 128);

    // Reset in the middle of a burst.
    dofs = 16'h5000;
    w0 = n_wr;
    d0 = n_done;
    do_req(32'h0000_6000, 0, 1'b0);
    beats(0, 70, -1, -1, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_arvalid", 32'(arvalid), 0);
    chk("mid_rst_rready", 32'(rready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    chk("rel_req_ready", 32'(req_ready), 1);
    chk("rst_writes", 32'(n_wr - w0), 70);
    chk("rst_q_empty", 32'(q_wr.size()), 0);
    rvalid = 1'b1;
    rdata = 16'hbeef;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    chk("post_rst_rready", 32'(rready), 0);
    chk("post_rst_writes", 32'(n_wr - w0), 70);
    chk("post_rst_dones", 32'(n_done - d0), 0);

    // req_valid held with a new address during a fill.
    dofs = 16'h6000;
    d0 = n_done;
    q_err.push_back(1'b0);
    do_req(32'h0000_7000, 0, 1'b1);
    beats(0, 64, -1, -1, 1'b0);
    req_addr = 32'h0000_7100;
    beats(64, 100, -1, -1, 1'b0);
    chk("hold_arvalid", 32'(arvalid), 0);
    chk("hold_araddr", araddr, 32'h0000_7000);
    beats(100, 128, 127, -1, 1'b0);
    chk("hold_no_ar", 32'(arvalid), 0);
    wait_done(d0);
    k = 0;
    while (!arvalid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("second_ar", 32'(arvalid), 1);
    chk("second_addr", araddr, 32'h0000_7100);
    req_valid = 1'b0;
    d0 = n_done;
    q_err.push_back(1'b0);
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    beats(0, 128, 127, -1, 1'b0);
    wait_done(d0);

    repeat (3) @(posedge clk);
    #1;
    chk("end_q_wr", 32'(q_wr.size()), 0);
    chk("end_q_err", 32'(q_err.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_fill_ctrl.md
DRAM_FILL_CTRL -- requirements
Module: dram_fill_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ID_WIDTH, 4, AXI ID width.
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 16, AXI/SRAM data width.
- BURST_LEN, 128, beats per fill (arlen = BURST_LEN-1).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, asynchronous active-high reset (1 = reset).
- req_valid, in, 1, fill request.
- req_addr, in, ADDR_WIDTH, byte base address, 256-byte aligned.
- req_ready, out, 1, high only in IDLE.
- arid/araddr/arlen/arsize/arburst, out, ID_WIDTH/ADDR_WIDTH/7/3/2, AXI read address fields.
- arvalid, out, 1, AXI read address valid.
- arready, in, 1, AXI read address ready.
- rdata/rresp/rlast/rvalid, in, DATA_WIDTH/2/1/1, AXI read data channel.
- rready, out, 1, AXI read data ready.
- sram_we, out, 1, local SRAM write strobe.
- sram_addr, out, 7, local SRAM word address.
- sram_wdata, out, DATA_WIDTH, local SRAM write data.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, status, valid while done = 1.

Function
REQ-003 States: IDLE, AR, RD, FIN. All outputs are registered.
REQ-004 IDLE: on req_valid, latch req_addr into araddr, then go to AR with arvalid = 1.
REQ-005 AR: hold arvalid and araddr stable until arready; on the handshake, drop arvalid, go to RD, and set rready = 1.
REQ-006 Constant AXI fields: arid = 0, arsize = 3'b001, arburst = 2'b01 (INCR), arlen = 7'd127.
REQ-007 RD: each rvalid & rready beat produces a registered SRAM write one cycle later. sram_we = 1, sram_wdata = rdata, and sram_addr = the beat counter value (0..127).
REQ-008 The beat counter is 7 bits, resets to 0 at each AR handshake, and increments per beat.
REQ-009 The burst ends only on a beat with rlast = 1. That beat drops rready and moves to FIN.
REQ-010 err is sticky within a fill. It sets if any beat has rresp != 2'b00. It also sets if rlast arrives with count != 127, or if count is 127 without rlast.
REQ-011 Beats that would exceed 128 are accepted but not written (sram_we = 0). They set err.
REQ-012 FIN: lasts one cycle, one cycle after the final SRAM write. done = 1, err is valid, then return to IDLE. err clears on the next request.
REQ-013 Fill latency with arready and rvalid always high: AR handshake at cycle 1 after request, final write at cycle 130, done at cycle 131.
REQ-014 req_valid is ignored while busy. A request is never queued.
REQ-015 rvalid outside RD is ignored, and rready stays 0.

Reset
REQ-016 Reset is asynchronous and active-high on rst_n. It forces state = IDLE and returns within one edge even mid-burst.
REQ-017 Reset values: arvalid = 0, rready = 0, sram_we = 0, done = 0, err = 0, busy = 0, araddr = 0, sram_addr = 0, sram_wdata = 0, counter = 0. req_ready goes to 1 after reset release.

Structure
REQ-018 A shared package dram_pkg holds ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, BURST_LEN, the AXI constants (SIZE_2B, BURST_INCR, RESP_OKAY), and the fill_state_t enum.
REQ-019 No sub-module is required. The FSM, counter and SRAM write stage are in one module.

Verification
REQ-020 Request 0x0000_1000, arready after 3 cycles, 128 beats with data = index, rlast on beat 127. Required: SRAM[i] = i, done once, err = 0.
REQ-021 rvalid toggles 1/0 randomly through the burst. Required: exactly 128 writes with contiguous addresses, and no write on idle cycles.
REQ-022 rresp = 2'b10 on beat 40. Required: all 128 beats written, done with err = 1.
REQ-023 rlast on beat 63. Required: FIN after 64 writes, err = 1. A second request of 0x1100 then completes with err = 0.
REQ-024 rst_n pulsed high at beat 70. Required: arvalid = rready = busy = 0 immediately, req_ready = 1 after release, later beats ignored.
REQ-025 req_valid held high during a fill, plus a new address. Required: no second AR until after done, and araddr unchanged mid-fill.
